// File: rtl/light_sequencer.sv
// Tick-driven traffic lamp sequencer: turns the 2-bit traffic-mode code into
// North-South / East-West lamp drives and a pedestrian walk lamp.
module light_sequencer #(
  parameter int G_TIME    = 8,
  parameter int Y_TIME    = 3,
  parameter int AR_TIME   = 1,
  parameter int WALK_TIME = 6,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode,
  output logic [2:0] nsLight,
  output logic [2:0] ewLight,
  output logic       walk
);

  typedef enum logic [3:0] {
    NS_G,
    NS_Y,
    AR_A,
    EW_G,
    EW_Y,
    AR_B,
    WALK,
    EMG,
    NIGHT
  } state_t;

  localparam logic [1:0] MODE_DAY   = 2'b00;
  localparam logic [1:0] MODE_NIGHT = 2'b01;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMG   = 2'b11;

  localparam logic [CNT_W-1:0] G_LOAD    = CNT_W'(G_TIME - 1);
  localparam logic [CNT_W-1:0] Y_LOAD    = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LOAD   = CNT_W'(AR_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_TIME - 1);

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic             flash, flash_n;
  logic             ped_served, ped_served_n;

  logic [1:0]       eff_mode;
  logic             expired;
  logic [CNT_W-1:0] timer_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= AR_B;
      timer      <= AR_LOAD;
      flash      <= 1'b1;
      ped_served <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      flash      <= flash_n;
      ped_served <= ped_served_n;
    end
  end

  // A served pedestrian request degrades to day mode until mode leaves 10.
  always_comb begin
    eff_mode  = (mode == MODE_PED && ped_served) ? MODE_DAY : mode;
    expired   = (timer == '0);
    timer_dec = expired ? timer : timer - 1'b1;
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    flash_n      = flash;
    ped_served_n = ped_served;

    if (tick) begin
      timer_n = timer_dec;
      case (state)
        NS_G: begin
          if (expired || eff_mode != MODE_DAY) begin
            state_n = NS_Y;
            timer_n = Y_LOAD;
          end
        end
        EW_G: begin
          if (expired || eff_mode != MODE_DAY) begin
            state_n = EW_Y;
            timer_n = Y_LOAD;
          end
        end
        NS_Y: begin
          if (expired) begin
            state_n = AR_A;
            timer_n = AR_LOAD;
          end
        end
        EW_Y: begin
          if (expired) begin
            state_n = AR_B;
            timer_n = AR_LOAD;
          end
        end
        AR_A, AR_B: begin
          // All-red exit target is chosen by mode priority, emergency first.
          if (expired) begin
            if (mode == MODE_EMG) begin
              state_n = EMG;
            end else if (mode == MODE_PED && !ped_served) begin
              state_n = WALK;
              timer_n = WALK_LOAD;
            end else if (mode == MODE_NIGHT) begin
              state_n = NIGHT;
              flash_n = 1'b1;
            end else if (state == AR_A) begin
              state_n = EW_G;
              timer_n = G_LOAD;
            end else begin
              state_n = NS_G;
              timer_n = G_LOAD;
            end
          end
        end
        WALK: begin
          if (mode == MODE_EMG) begin
            state_n = EMG;
          end else if (expired) begin
            state_n      = AR_B;
            timer_n      = AR_LOAD;
            ped_served_n = 1'b1;
          end
        end
        EMG: begin
          if (mode != MODE_EMG) begin
            state_n = AR_B;
            timer_n = AR_LOAD;
          end
        end
        NIGHT: begin
          if (mode == MODE_EMG) begin
            state_n = EMG;
          end else if (mode == MODE_DAY || mode == MODE_PED) begin
            state_n = AR_B;
            timer_n = AR_LOAD;
          end else begin
            flash_n = ~flash;
          end
        end
        default: begin
          state_n = AR_B;
          timer_n = AR_LOAD;
        end
      endcase
    end

    // Withdrawing the request always wins, even on the walk-expiry edge.
    if (mode != MODE_PED) ped_served_n = 1'b0;
  end

  always_comb begin
    nsLight = LAMP_R;
    ewLight = LAMP_R;
    walk    = 1'b0;
    case (state)
      NS_G:    nsLight = LAMP_G;
      NS_Y:    nsLight = LAMP_Y;
      EW_G:    ewLight = LAMP_G;
      EW_Y:    ewLight = LAMP_Y;
      WALK:    walk    = 1'b1;
      NIGHT: begin
        nsLight = flash ? LAMP_Y : LAMP_OFF;
        ewLight = flash ? LAMP_R : LAMP_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer: table-driven day cycle, directed
// corner sequences and randomized stimulus against a phase/remaining-ticks model.
module tb_light_sequencer;

  localparam int G_TIME    = 8;
  localparam int Y_TIME    = 3;
  localparam int AR_TIME   = 1;
  localparam int WALK_TIME = 6;
  localparam int CNT_W     = 4;

  localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_EWG = 3, P_EWY = 4,
                 P_ARB = 5, P_WALK = 6, P_EMG = 7, P_NIGHT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] mode;
  logic [2:0] nsLight;
  logic [2:0] ewLight;
  logic       walk;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase and ticks still left in it (including this one).
  int m_phase;
  int m_left;
  bit m_flash;
  bit m_served;

  typedef struct {
    bit         tick;
    logic [1:0] mode;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } vec_t;

  vec_t dayTab[25];

  light_sequencer #(
    .G_TIME(G_TIME), .Y_TIME(Y_TIME), .AR_TIME(AR_TIME),
    .WALK_TIME(WALK_TIME), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode),
    .nsLight(nsLight), .ewLight(ewLight), .walk(walk)
  );

  always #5 clk = ~clk;

  function automatic int phaseLen(int p);
    case (p)
      P_NSG, P_EWG: return G_TIME;
      P_NSY, P_EWY: return Y_TIME;
      P_ARA, P_ARB: return AR_TIME;
      P_WALK:       return WALK_TIME;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [2:0] expNs(int p, bit f);
    case (p)
      P_NSG:   return 3'b001;
      P_NSY:   return 3'b010;
      P_NIGHT: return f ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] expEw(int p, bit f);
    case (p)
      P_EWG:   return 3'b001;
      P_EWY:   return 3'b010;
      P_NIGHT: return f ? 3'b100 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  task automatic modelReset();
    m_phase  = P_ARB;
    m_left   = AR_TIME;
    m_flash  = 1'b1;
    m_served = 1'b0;
  endtask

  task automatic enterPhase(int p);
    m_phase = p;
    m_left  = phaseLen(p);
    if (p == P_NIGHT) m_flash = 1'b1;
  endtask

  task automatic modelStep(bit t, logic [1:0] md);
    bit         last;
    bit         moved;
    bit         servedNext;
    logic [1:0] eff;
    if (rst) begin
      modelReset();
    end else begin
      servedNext = m_served;
      if (t) begin
        last  = (m_left == 1);
        eff   = (md == 2'b10 && m_served) ? 2'b00 : md;
        moved = 1'b0;
        case (m_phase)
          P_NSG: if (last || eff != 2'b00) begin enterPhase(P_NSY); moved = 1'b1; end
          P_EWG: if (last || eff != 2'b00) begin enterPhase(P_EWY); moved = 1'b1; end
          P_NSY: if (last) begin enterPhase(P_ARA); moved = 1'b1; end
          P_EWY: if (last) begin enterPhase(P_ARB); moved = 1'b1; end
          P_ARA, P_ARB: begin
            if (last) begin
              moved = 1'b1;
              if (md == 2'b11) enterPhase(P_EMG);
              else if (md == 2'b10 && !m_served) enterPhase(P_WALK);
              else if (md == 2'b01) enterPhase(P_NIGHT);
              else enterPhase((m_phase == P_ARA) ? P_EWG : P_NSG);
            end
          end
          P_WALK: begin
            if (md == 2'b11) begin
              enterPhase(P_EMG); moved = 1'b1;
            end else if (last) begin
              enterPhase(P_ARB); moved = 1'b1; servedNext = 1'b1;
            end
          end
          P_EMG: if (md != 2'b11) begin enterPhase(P_ARB); moved = 1'b1; end
          default: begin
            if (md == 2'b11) begin enterPhase(P_EMG); moved = 1'b1; end
            else if (md == 2'b00 || md == 2'b10) begin enterPhase(P_ARB); moved = 1'b1; end
            else m_flash = ~m_flash;
          end
        endcase
        if (!moved && m_left > 1) m_left--;
      end
      if (md != 2'b10) servedNext = 1'b0;
      m_served = servedNext;
    end
  endtask

  task automatic checkOutput(string name, logic [2:0] ens, logic [2:0] eew, logic ewalk);
    checks++;
    if ({nsLight, ewLight, walk} !== {ens, eew, ewalk}) begin
      errors++;
      $display("[TB] FAIL %s: got ns=%b ew=%b walk=%b, want ns=%b ew=%b walk=%b",
               name, nsLight, ewLight, walk, ens, eew, ewalk);
    end
  endtask

  task automatic checkModel(string name);
    checkOutput(name, expNs(m_phase, m_flash), expEw(m_phase, m_flash), m_phase == P_WALK);
  endtask

  task automatic applyStimulus(bit t, logic [1:0] md);
    tick = t;
    mode = md;
    modelStep(t, md);
    @(posedge clk);
    #1;
  endtask

  task automatic stepCheck(bit t, logic [1:0] md, string name);
    applyStimulus(t, md);
    checkModel(name);
  endtask

  task automatic runUntil(int target, logic [1:0] md, string name);
    for (int i = 0; i < 200 && m_phase != target; i++) stepCheck(1'b1, md, name);
    if (m_phase != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: phase=%0d, want %0d", name, m_phase, target);
    end
  endtask

  task automatic fillRange(int first, int last, logic [2:0] ns, logic [2:0] ew);
    for (int i = first; i <= last; i++) begin
      dayTab[i - 1].tick = 1'b1;
      dayTab[i - 1].mode = 2'b00;
      dayTab[i - 1].ns   = ns;
      dayTab[i - 1].ew   = ew;
      dayTab[i - 1].walk = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fillRange(1, 8, 3'b001, 3'b100);
    fillRange(9, 11, 3'b010, 3'b100);
    fillRange(12, 12, 3'b100, 3'b100);
    fillRange(13, 20, 3'b100, 3'b001);
    fillRange(21, 23, 3'b100, 3'b010);
    fillRange(24, 24, 3'b100, 3'b100);
    fillRange(25, 25, 3'b001, 3'b100);

    rst  = 1'b1;
    tick = 1'b0;
    mode = 2'b00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", 3'b100, 3'b100, 1'b0);
    rst = 1'b0;

    // Day cycle from reset, edge by edge.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(dayTab[i].tick, dayTab[i].mode);
      checkOutput($sformatf("day edge %0d", i + 1), dayTab[i].ns, dayTab[i].ew, dayTab[i].walk);
    end

    // Pedestrian request raised two ticks into a fresh green.
    repeat (2) stepCheck(1'b1, 2'b00, "ped pre-green");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b10);
      checkOutput("ped NS_Y", 3'b010, 3'b100, 1'b0);
    end
    applyStimulus(1'b1, 2'b10);
    checkOutput("ped AR_A", 3'b100, 3'b100, 1'b0);
    for (int i = 0; i < WALK_TIME; i++) begin
      applyStimulus(1'b1, 2'b10);
      checkOutput("ped WALK", 3'b100, 3'b100, 1'b1);
    end
    applyStimulus(1'b1, 2'b10);
    checkOutput("ped AR_B", 3'b100, 3'b100, 1'b0);
    for (int i = 0; i < G_TIME; i++) begin
      applyStimulus(1'b1, 2'b10);
      checkOutput("ped served green", 3'b001, 3'b100, 1'b0);
    end
    applyStimulus(1'b1, 2'b10);
    checkOutput("ped green expiry", 3'b010, 3'b100, 1'b0);

    // Emergency aborting a walk, then recovery through AR_B.
    stepCheck(1'b1, 2'b00, "clear served");
    runUntil(P_WALK, 2'b10, "reach walk");
    stepCheck(1'b1, 2'b10, "mid walk");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 2'b11);
      checkOutput("emg hold", 3'b100, 3'b100, 1'b0);
    end
    applyStimulus(1'b1, 2'b00);
    checkOutput("emg exit AR_B", 3'b100, 3'b100, 1'b0);
    applyStimulus(1'b1, 2'b00);
    checkOutput("emg exit NS_G", 3'b001, 3'b100, 1'b0);

    // Night entered from EW green.
    runUntil(P_EWG, 2'b00, "reach EW_G");
    for (int i = 0; i < Y_TIME; i++) begin
      applyStimulus(1'b1, 2'b01);
      checkOutput("night EW_Y", 3'b100, 3'b010, 1'b0);
    end
    applyStimulus(1'b1, 2'b01);
    checkOutput("night AR_B", 3'b100, 3'b100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b01);
      if (i % 2 == 0) checkOutput("night flash on", 3'b010, 3'b100, 1'b0);
      else checkOutput("night flash off", 3'b000, 3'b000, 1'b0);
    end
    applyStimulus(1'b1, 2'b00);
    checkOutput("night exit AR_B", 3'b100, 3'b100, 1'b0);
    applyStimulus(1'b1, 2'b00);
    checkOutput("night exit NS_G", 3'b001, 3'b100, 1'b0);

    // Tick every 4th clock stretches every phase by four.
    for (int i = 0; i < 120; i++) stepCheck((i % 4) == 3, 2'b00, "tick gated");
    for (int i = 0; i < 400 && !(m_phase == P_NSG && m_left < G_TIME); i++)
      stepCheck((i % 4) == 3, 2'b00, "tick gated to NS_G");
    checkOutput("gated mid NS_G", 3'b001, 3'b100, 1'b0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async reset", 3'b100, 3'b100, 1'b0);
    applyStimulus(1'b1, 2'b00);
    checkOutput("reset held", 3'b100, 3'b100, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 2'b00);
    checkOutput("after reset NS_G", 3'b001, 3'b100, 1'b0);

    // Randomized mode/tick/reset traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] md;
      md = mode;
      if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        modelReset();
        stepCheck(1'b1, md, "random reset");
        rst = 1'b0;
      end else begin
        stepCheck($urandom_range(0, 3) != 0, md, "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
